// File: rtl/icache_sa_if.sv
// Fetch-side and memory-side signals of the set-associative instruction cache.
// The cache takes the slave view; the Instruction Unit plus memory controller take the master view.
interface icache_sa_if #(
  parameter int BLOCK_WIDTH = 4
);
  localparam int LINE_BITS = 8 << BLOCK_WIDTH;

  logic                   instrReqIn;
  logic [31:0]            instrAddrIn;
  logic                   instrOutValid;
  logic [31:0]            instrOut;
  logic                   missOut;
  logic                   flushIn;
  logic                   memReqOut;
  logic [31-BLOCK_WIDTH:0] memAddrOut;
  logic                   memReqReady;
  logic                   memDataValid;
  logic [LINE_BITS-1:0]   memDataIn;

  modport slave (
    input  instrReqIn, instrAddrIn, flushIn, memReqReady, memDataValid, memDataIn,
    output instrOutValid, instrOut, missOut, memReqOut, memAddrOut
  );

  modport master (
    output instrReqIn, instrAddrIn, flushIn, memReqReady, memDataValid, memDataIn,
    input  instrOutValid, instrOut, missOut, memReqOut, memAddrOut
  );
endinterface

// File: rtl/icache_sa.sv
// Set-associative instruction cache: zero-latency hits, single outstanding line refill,
// lowest-invalid-way then round-robin victim selection, and whole-cache flush.
module icache_sa #(
  parameter int BLOCK_WIDTH = 4,
  parameter int SET_WIDTH   = 3,
  parameter int WAYS        = 2
) (
  input  logic       clkIn,
  input  logic       resetIn,
  icache_sa_if.slave bus
);
  localparam int LINE_BITS = 8 << BLOCK_WIDTH;
  localparam int WORDS     = LINE_BITS / 32;
  localparam int SETS      = 1 << SET_WIDTH;
  localparam int TAG_W     = 32 - BLOCK_WIDTH - SET_WIDTH;
  localparam int PTR_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} stateType;

  stateType                stateReg;
  logic [31-BLOCK_WIDTH:0] lineAddrReg;
  logic                    memReqReg;
  logic                    discardReg;
  logic                    advanceReg;
  logic [PTR_W-1:0]        victimPtr [SETS];

  logic [SET_WIDTH-1:0]    reqSet;
  logic [TAG_W-1:0]        reqTag;
  logic [BLOCK_WIDTH-3:0]  reqWord;
  logic [SET_WIDTH-1:0]    fillSet;
  logic [TAG_W-1:0]        fillTag;
  logic                    fillWrite;
  logic [WAYS-1:0]         wayHit;
  logic [WAYS-1:0]         fillSetValid;
  logic [WAYS-1:0][31:0]   wayWord;
  logic [PTR_W-1:0]        victimWay;
  logic [PTR_W-1:0]        nextPtr;
  logic                    fillInvalid;
  logic                    lookupHit;
  logic [31:0]             hitWord;
  logic                    unusedAddrBits;

  assign reqSet         = bus.instrAddrIn[BLOCK_WIDTH+SET_WIDTH-1:BLOCK_WIDTH];
  assign reqTag         = bus.instrAddrIn[31:BLOCK_WIDTH+SET_WIDTH];
  assign reqWord        = bus.instrAddrIn[BLOCK_WIDTH-1:2];
  assign unusedAddrBits = ^bus.instrAddrIn[1:0];
  assign fillSet        = lineAddrReg[SET_WIDTH-1:0];
  assign fillTag        = lineAddrReg[31-BLOCK_WIDTH:SET_WIDTH];

  // A line arriving after a flush during the refill is dropped rather than written.
  assign fillWrite = (stateReg == WAIT) && bus.memDataValid && !discardReg && !bus.flushIn;

  for (genvar gi = 0; gi < WAYS; gi++) begin : gWay
    logic [SETS-1:0]       validBits;
    logic [TAG_W-1:0]      tagMem  [SETS];
    logic [WORDS-1:0][31:0] dataMem [SETS];
    logic                  wayWrite;

    assign wayWrite = fillWrite && (victimWay == PTR_W'(gi));

    always_ff @(posedge clkIn or negedge resetIn) begin
      if (!resetIn) begin
        validBits <= '0;
      end else if (bus.flushIn) begin
        validBits <= '0;
      end else if (wayWrite) begin
        validBits[fillSet] <= 1'b1;
      end
    end

    always_ff @(posedge clkIn) begin
      if (wayWrite) begin
        tagMem[fillSet]  <= fillTag;
        dataMem[fillSet] <= bus.memDataIn;
      end
    end

    assign wayHit[gi]       = validBits[reqSet] && (tagMem[reqSet] == reqTag);
    assign wayWord[gi]      = dataMem[reqSet][reqWord];
    assign fillSetValid[gi] = validBits[fillSet];
  end

  always_comb begin
    victimWay   = victimPtr[fillSet];
    fillInvalid = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!fillSetValid[w]) begin
        victimWay   = PTR_W'(w);
        fillInvalid = 1'b1;
      end
    end
  end

  assign nextPtr = (WAYS == 1) ? '0 : victimPtr[fillSet] + PTR_W'(1);

  always_comb begin
    hitWord = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (wayHit[w]) hitWord = wayWord[w];
    end
  end

  assign lookupHit         = (stateReg == IDLE) && bus.instrReqIn && (|wayHit);
  assign bus.instrOutValid = lookupHit;
  assign bus.instrOut      = lookupHit ? hitWord : '0;
  assign bus.missOut       = (stateReg != IDLE) || (bus.instrReqIn && !lookupHit);
  assign bus.memReqOut     = memReqReg;
  assign bus.memAddrOut    = lineAddrReg;

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      stateReg    <= IDLE;
      lineAddrReg <= '0;
      memReqReg   <= 1'b0;
      discardReg  <= 1'b0;
      advanceReg  <= 1'b0;
      for (int s = 0; s < SETS; s++) victimPtr[s] <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (bus.instrReqIn && !lookupHit) begin
            lineAddrReg <= bus.instrAddrIn[31:BLOCK_WIDTH];
            memReqReg   <= 1'b1;
            stateReg    <= REQ;
          end
        end
        REQ: begin
          if (bus.flushIn) discardReg <= 1'b1;
          if (bus.memReqReady) begin
            memReqReg <= 1'b0;
            stateReg  <= WAIT;
          end
        end
        WAIT: begin
          if (bus.flushIn) discardReg <= 1'b1;
          if (bus.memDataValid) begin
            // Only a replacement of a valid way moves the round-robin pointer.
            advanceReg <= !fillInvalid && !discardReg && !bus.flushIn;
            stateReg   <= FILL;
          end
        end
        FILL: begin
          if (advanceReg) victimPtr[fillSet] <= nextPtr;
          discardReg <= 1'b0;
          advanceReg <= 1'b0;
          stateReg   <= IDLE;
        end
        default: stateReg <= IDLE;
      endcase
      if (bus.flushIn) begin
        for (int s = 0; s < SETS; s++) victimPtr[s] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_icache_sa.sv
// Scenario bench for icache_sa: a default 2-way instance and a 4-way, 32-byte-line instance.
module tb_icache_sa;
  typedef struct {
    logic [31:0] addr;
    logic        valid;
    logic [31:0] data;
  } lookupExp_t;

  bit   clk;
  logic rstN;
  int   checks;
  int   errors;
  lookupExp_t expQ[$];

  icache_sa_if #(.BLOCK_WIDTH(4)) bus ();
  icache_sa_if #(.BLOCK_WIDTH(5)) bus4 ();

  icache_sa #(.BLOCK_WIDTH(4), .SET_WIDTH(3), .WAYS(2)) dut (
    .clkIn(clk), .resetIn(rstN), .bus(bus));
  icache_sa #(.BLOCK_WIDTH(5), .SET_WIDTH(3), .WAYS(4)) dut4 (
    .clkIn(clk), .resetIn(rstN), .bus(bus4));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference line contents: every word encodes its own byte address.
  function automatic logic [31:0] patWord(input bit sel, input logic [31:0] a);
    if (sel) return {4'h5, a[23:5], 6'd0, a[4:2]};
    return {4'hA, a[23:4], 6'd0, a[3:2]};
  endfunction

  function automatic logic [255:0] mkLine(input bit sel, input logic [31:0] a);
    logic [255:0] line;
    logic [31:0]  base;
    line = '0;
    base = sel ? {a[31:5], 5'd0} : {a[31:4], 4'd0};
    for (int w = 0; w < (sel ? 8 : 4); w++) line[w*32 +: 32] = patWord(sel, base + 32'(w * 4));
    return line;
  endfunction

  task automatic setFetch(input bit sel, input logic req, input logic [31:0] a);
    if (sel) begin bus4.instrReqIn = req; bus4.instrAddrIn = a; end
    else     begin bus.instrReqIn  = req; bus.instrAddrIn  = a; end
  endtask

  task automatic setMem(input bit sel, input logic rdy, input logic vld, input logic [255:0] line);
    if (sel) begin bus4.memReqReady = rdy; bus4.memDataValid = vld; bus4.memDataIn = line; end
    else     begin bus.memReqReady  = rdy; bus.memDataValid  = vld; bus.memDataIn  = line[127:0]; end
  endtask

  task automatic clearInputs();
    setFetch(0, 0, 0); setFetch(1, 0, 0);
    setMem(0, 0, 0, '0); setMem(1, 0, 0, '0);
    bus.flushIn = 0; bus4.flushIn = 0;
  endtask

  task automatic doReset();
    clearInputs();
    rstN = 0;
    @(posedge clk); @(posedge clk); #1;
    rstN = 1;
  endtask

  // One fetch cycle: drive, sample away from the edge, drop the request after the edge.
  task automatic lookup(input bit sel, input logic [31:0] a, output logic v, output logic [31:0] d, output logic m);
    setFetch(sel, 1'b1, a);
    @(negedge clk);
    if (sel) begin v = bus4.instrOutValid; d = bus4.instrOut; m = bus4.missOut; end
    else     begin v = bus.instrOutValid;  d = bus.instrOut;  m = bus.missOut;  end
    @(posedge clk); #1;
    setFetch(sel, 1'b0, 32'h0);
  endtask

  // Memory responder for one refill; waited = -1 when no request appeared in time.
  task automatic serviceRefill(input bit sel, input logic [255:0] line, output logic [27:0] gotAddr, output int waited);
    logic req;
    waited  = -1;
    gotAddr = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req = sel ? bus4.memReqOut : bus.memReqOut;
      if (req) begin
        waited  = i;
        gotAddr = sel ? {1'b0, bus4.memAddrOut} : bus.memAddrOut;
        break;
      end
    end
    if (waited < 0) return;
    @(posedge clk); #1 setMem(sel, 1, 0, '0);
    @(posedge clk); #1 setMem(sel, 0, 1, line);
    @(posedge clk); #1 setMem(sel, 0, 0, '0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    lookupExp_t e;
    logic v, m;
    logic [31:0] d;
    clearInputs();
    rstN = 0;
    #2;
    checks++;
    if (bus.memReqOut !== 1'b0 || bus.instrOutValid !== 1'b0 || bus.missOut !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got memReq=%b valid=%b miss=%b, expected 0 0 0",
               bus.memReqOut, bus.instrOutValid, bus.missOut);
    end
    @(posedge clk); @(posedge clk); #1 rstN = 1;
    expQ.push_back('{32'h0000_0040, 1'b0, 32'h0});
    e = expQ.pop_front();
    lookup(0, e.addr, v, d, m);
    checks++;
    if (v !== e.valid || d !== e.data || m !== !e.valid) begin
      errors++;
      $display("FAIL cold_lookup %h: got valid=%b data=%h miss=%b, expected valid=%b data=%h miss=%b",
               e.addr, v, d, m, e.valid, e.data, !e.valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_first_fill();
    lookupExp_t e;
    logic v, m;
    logic [31:0] d;
    logic [27:0] ga;
    int wt;
    logic [255:0] line;
    doReset();
    expQ.push_back('{32'h0000_0104, 1'b0, 32'h0});
    e = expQ.pop_front();
    lookup(0, e.addr, v, d, m);
    checks++;
    if (v !== e.valid || d !== e.data || m !== !e.valid) begin
      errors++;
      $display("FAIL first_miss %h: got valid=%b data=%h miss=%b, expected valid=%b data=%h miss=%b",
               e.addr, v, d, m, e.valid, e.data, !e.valid);
    end
    line = mkLine(0, 32'h100);
    line[63:32] = 32'hDEAD_BEEF;
    serviceRefill(0, line, ga, wt);
    checks++;
    if (wt !== 0 || ga !== 28'h000_0010) begin
      errors++;
      $display("FAIL first_request: got wait=%0d addr=%h, expected wait=0 addr=0000010", wt, ga);
    end
    expQ.push_back('{32'h0000_0104, 1'b1, 32'hDEAD_BEEF});
    expQ.push_back('{32'h0000_0100, 1'b1, patWord(0, 32'h100)});
    expQ.push_back('{32'h0000_010C, 1'b1, patWord(0, 32'h10C)});
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      lookup(0, e.addr, v, d, m);
      checks++;
      if (v !== e.valid || d !== e.data || m !== !e.valid) begin
        errors++;
        $display("FAIL first_hit %h: got valid=%b data=%h miss=%b, expected valid=%b data=%h miss=%b",
                 e.addr, v, d, m, e.valid, e.data, !e.valid);
      end
    end
    $display("test_first_fill done");
  endtask

  task automatic test_eviction();
    lookupExp_t e;
    logic v, m;
    logic [31:0] d;
    logic [27:0] ga;
    int wt;
    logic [31:0] fills [3] = '{32'h000, 32'h080, 32'h100};
    doReset();
    for (int i = 0; i < 3; i++) begin
      expQ.push_back('{fills[i], 1'b0, 32'h0});
      e = expQ.pop_front();
      lookup(0, e.addr, v, d, m);
      checks++;
      if (v !== e.valid || m !== !e.valid) begin
        errors++;
        $display("FAIL evict_fill %h: got valid=%b miss=%b, expected valid=0 miss=1", e.addr, v, m);
      end
      serviceRefill(0, mkLine(0, fills[i]), ga, wt);
    end
    // Third fill took way 0 (0x000); the pointer now names way 1 (0x080).
    expQ.push_back('{32'h088, 1'b1, patWord(0, 32'h088)});
    expQ.push_back('{32'h10C, 1'b1, patWord(0, 32'h10C)});
    expQ.push_back('{32'h004, 1'b0, 32'h0});
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      lookup(0, e.addr, v, d, m);
      checks++;
      if (v !== e.valid || d !== e.data || m !== !e.valid) begin
        errors++;
        $display("FAIL evict_third %h: got valid=%b data=%h miss=%b, expected valid=%b data=%h miss=%b",
                 e.addr, v, d, m, e.valid, e.data, !e.valid);
      end
    end
    serviceRefill(0, mkLine(0, 32'h000), ga, wt);
    expQ.push_back('{32'h008, 1'b1, patWord(0, 32'h008)});
    expQ.push_back('{32'h104, 1'b1, patWord(0, 32'h104)});
    expQ.push_back('{32'h084, 1'b0, 32'h0});
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      lookup(0, e.addr, v, d, m);
      checks++;
      if (v !== e.valid || d !== e.data || m !== !e.valid) begin
        errors++;
        $display("FAIL evict_fourth %h: got valid=%b data=%h miss=%b, expected valid=%b data=%h miss=%b",
                 e.addr, v, d, m, e.valid, e.data, !e.valid);
      end
    end
    $display("test_eviction done");
  endtask

  task automatic test_req_hold();
    lookupExp_t e;
    logic v, m;
    logic [31:0] d;
    logic [27:0] ga;
    int wt;
    doReset();
    lookup(0, 32'h200, v, d, m);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.memReqOut !== 1'b1 || bus.memAddrOut !== 28'h000_0020 || bus.missOut !== 1'b1) begin
        errors++;
        $display("FAIL req_hold cycle %0d: got memReq=%b addr=%h miss=%b, expected 1 0000020 1",
                 i, bus.memReqOut, bus.memAddrOut, bus.missOut);
      end
      @(posedge clk); #1;
    end
    serviceRefill(0, mkLine(0, 32'h200), ga, wt);
    expQ.push_back('{32'h208, 1'b1, patWord(0, 32'h208)});
    e = expQ.pop_front();
    lookup(0, e.addr, v, d, m);
    checks++;
    if (v !== e.valid || d !== e.data || m !== !e.valid) begin
      errors++;
      $display("FAIL req_hold_hit %h: got valid=%b data=%h miss=%b, expected valid=%b data=%h miss=%b",
               e.addr, v, d, m, e.valid, e.data, !e.valid);
    end
    $display("test_req_hold done");
  endtask

  task automatic test_flush();
    lookupExp_t e;
    logic v, m;
    logic [31:0] d;
    logic [27:0] ga;
    int wt;
    doReset();
    lookup(0, 32'h300, v, d, m);
    @(posedge clk); #1 setMem(0, 1, 0, '0);
    @(posedge clk); #1 setMem(0, 0, 0, '0); bus.flushIn = 1;
    @(posedge clk); #1 bus.flushIn = 0; setMem(0, 0, 1, mkLine(0, 32'h300));
    @(posedge clk); #1 setMem(0, 0, 0, '0);
    @(posedge clk); #1;
    expQ.push_back('{32'h304, 1'b0, 32'h0});
    e = expQ.pop_front();
    lookup(0, e.addr, v, d, m);
    checks++;
    if (v !== e.valid || d !== e.data || m !== !e.valid) begin
      errors++;
      $display("FAIL flush_wait_refetch %h: got valid=%b data=%h miss=%b, expected valid=%b data=%h miss=%b",
               e.addr, v, d, m, e.valid, e.data, !e.valid);
    end
    @(negedge clk);
    checks++;
    if (bus.memReqOut !== 1'b1 || bus.memAddrOut !== 28'h000_0030) begin
      errors++;
      $display("FAIL flush_wait_rerequest: got memReq=%b addr=%h, expected 1 0000030", bus.memReqOut, bus.memAddrOut);
    end
    serviceRefill(0, mkLine(0, 32'h300), ga, wt);
    expQ.push_back('{32'h304, 1'b1, patWord(0, 32'h304)});
    e = expQ.pop_front();
    lookup(0, e.addr, v, d, m);
    checks++;
    if (v !== e.valid || d !== e.data || m !== !e.valid) begin
      errors++;
      $display("FAIL flush_refill_hit %h: got valid=%b data=%h miss=%b, expected valid=%b data=%h miss=%b",
               e.addr, v, d, m, e.valid, e.data, !e.valid);
    end
    // Flush while idle drops the line just confirmed present.
    bus.flushIn = 1;
    @(posedge clk); #1 bus.flushIn = 0;
    expQ.push_back('{32'h304, 1'b0, 32'h0});
    e = expQ.pop_front();
    lookup(0, e.addr, v, d, m);
    checks++;
    if (v !== e.valid || d !== e.data || m !== !e.valid) begin
      errors++;
      $display("FAIL flush_idle %h: got valid=%b data=%h miss=%b, expected valid=%b data=%h miss=%b",
               e.addr, v, d, m, e.valid, e.data, !e.valid);
    end
    $display("test_flush done");
  endtask

  task automatic test_reset_wait();
    lookupExp_t e;
    logic v, m;
    logic [31:0] d;
    logic [27:0] ga;
    int wt;
    doReset();
    lookup(0, 32'h500, v, d, m);
    serviceRefill(0, mkLine(0, 32'h500), ga, wt);
    lookup(0, 32'h404, v, d, m);
    @(posedge clk); #1 setMem(0, 1, 0, '0);
    @(posedge clk); #1 setMem(0, 0, 0, '0);
    #3 rstN = 0;
    #1;
    checks++;
    if (bus.memReqOut !== 1'b0 || bus.missOut !== 1'b0 || bus.instrOutValid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got memReq=%b miss=%b valid=%b, expected 0 0 0",
               bus.memReqOut, bus.missOut, bus.instrOutValid);
    end
    @(negedge clk) rstN = 1;
    @(posedge clk); #1 setMem(0, 0, 1, mkLine(0, 32'h400));
    @(posedge clk); #1 setMem(0, 0, 0, '0);
    @(negedge clk);
    checks++;
    if (bus.missOut !== 1'b0 || bus.memReqOut !== 1'b0) begin
      errors++;
      $display("FAIL late_data_idle: got miss=%b memReq=%b, expected 0 0", bus.missOut, bus.memReqOut);
    end
    @(posedge clk); #1;
    expQ.push_back('{32'h404, 1'b0, 32'h0});
    expQ.push_back('{32'h500, 1'b0, 32'h0});
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      lookup(0, e.addr, v, d, m);
      checks++;
      if (v !== e.valid || d !== e.data || m !== !e.valid) begin
        errors++;
        $display("FAIL reset_wait_lookup %h: got valid=%b data=%h miss=%b, expected valid=%b data=%h miss=%b",
                 e.addr, v, d, m, e.valid, e.data, !e.valid);
      end
    end
    $display("test_reset_wait done");
  endtask

  task automatic test_ways4();
    lookupExp_t e;
    logic v, m;
    logic [31:0] d;
    logic [27:0] ga;
    int wt;
    logic [255:0] line;
    logic [31:0] fills [4] = '{32'h100, 32'h200, 32'h300, 32'h400};
    doReset();
    lookup(1, 32'h01C, v, d, m);
    line = mkLine(1, 32'h000);
    line[255:224] = 32'hCAFE_F00D;
    serviceRefill(1, line, ga, wt);
    checks++;
    if (wt !== 0 || ga !== 28'h000_0000) begin
      errors++;
      $display("FAIL ways4_request: got wait=%0d addr=%h, expected wait=0 addr=0000000", wt, ga);
    end
    expQ.push_back('{32'h01C, 1'b1, 32'hCAFE_F00D});
    expQ.push_back('{32'h000, 1'b1, patWord(1, 32'h000)});
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      lookup(1, e.addr, v, d, m);
      checks++;
      if (v !== e.valid || d !== e.data || m !== !e.valid) begin
        errors++;
        $display("FAIL ways4_word %h: got valid=%b data=%h miss=%b, expected valid=%b data=%h miss=%b",
                 e.addr, v, d, m, e.valid, e.data, !e.valid);
      end
    end
    // Fill the other three ways of set 0, then a fifth line replaces way 0.
    for (int i = 0; i < 4; i++) begin
      lookup(1, fills[i], v, d, m);
      serviceRefill(1, mkLine(1, fills[i]), ga, wt);
    end
    expQ.push_back('{32'h104, 1'b1, patWord(1, 32'h104)});
    expQ.push_back('{32'h218, 1'b1, patWord(1, 32'h218)});
    expQ.push_back('{32'h31C, 1'b1, patWord(1, 32'h31C)});
    expQ.push_back('{32'h408, 1'b1, patWord(1, 32'h408)});
    expQ.push_back('{32'h01C, 1'b0, 32'h0});
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      lookup(1, e.addr, v, d, m);
      checks++;
      if (v !== e.valid || d !== e.data || m !== !e.valid) begin
        errors++;
        $display("FAIL ways4_evict %h: got valid=%b data=%h miss=%b, expected valid=%b data=%h miss=%b",
                 e.addr, v, d, m, e.valid, e.data, !e.valid);
      end
    end
    $display("test_ways4 done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstN   = 0;
    clearInputs();
    test_reset();
    test_first_fill();
    test_eviction();
    test_req_hold();
    test_flush();
    test_reset_wait();
    test_ways4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
